bitvault_initiator: RTL and testbench

Command-driven initiator that owns the access port of the BitVault register file (4 × 8-bit, write-enable + address + data). Accepts read/write commands from a host over a valid/ready handshake. Sequences the vault's `we`/`addr`/`data_in` pins, captures `data_out` after the vault's read latency, and returns one response per command. It sits between the control logic and the vault, which is never driven directly by anything else.

---
 rtl/bitvault_initiator.sv | 253 +++++++++++++++++++++++++
 tb/tb_bitvault_initiator.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitvault_initiator.sv
// ---------------------------------------------------------------------------------------------
// bitvault_initiator
//
// Sole owner of the BitVault register-file access port. A host hands in one read or write
// command at a time over a valid/ready handshake; the initiator drives the vault's
// we/addr/data_in pins, waits out the vault read latency and returns exactly one response
// per command over a second valid/ready handshake.
//
// Build option:
//   BITVAULT_WRITE_VERIFY_EN  when defined, every write is followed by a read-back of the same
//                             address. The response then carries the read-back value, and
//                             rsp_err flags a difference from the written data. When undefined,
//                             the verify state is not built, a write response echoes the write
//                             data and rsp_err is always 0.
//
// Parameters:
//   ADDR_W  vault address width
//   DATA_W  vault data width
//   RD_LAT  cycles from v_addr driven to v_data_out valid (0..3)
//
// Ports:
//   clk, rst             single rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; ready only while idle
//   cmd_write            1 = write, 0 = read
//   cmd_addr, cmd_wdata  command address and write data (wdata ignored for reads)
//   rsp_valid/rsp_ready  response handshake; response held stable until accepted
//   rsp_rdata            read data, read-back data, or write-data echo
//   rsp_err              write-verify mismatch
//   v_we, v_addr         vault write enable and address (registered)
//   v_data_in            vault write data (registered)
//   v_data_out           vault read data
//   busy                 high whenever the initiator is not idle
// ---------------------------------------------------------------------------------------------
module bitvault_initiator #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              v_we,
  output logic [ADDR_W-1:0] v_addr,
  output logic [DATA_W-1:0] v_data_in,
  input  logic [DATA_W-1:0] v_data_out,
  output logic              busy
);

  // Two bits cover the whole legal latency range 0..3.
  localparam int unsigned    CntW    = 2;
  localparam logic [CntW-1:0] LatInit = CntW'(RD_LAT);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrite   = 3'd1,
    StRdWait  = 3'd2,
    StResp    = 3'd3
`ifdef BITVAULT_WRITE_VERIFY_EN
    ,
    StVfyWait = 3'd4
`endif
  } state_e;

  // -------------------------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              v_we_q, v_we_d;
  logic [ADDR_W-1:0] v_addr_q, v_addr_d;
  logic [DATA_W-1:0] v_data_in_q, v_data_in_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic accept;
  logic cnt_zero;
  logic rsp_hs;

  // cmd_ready_q is only ever 1 while idle, so it doubles as the idle qualifier here.
  assign accept   = cmd_valid & cmd_ready_q;
  assign cnt_zero = (cnt_q == '0);
  assign rsp_hs   = rsp_valid_q & rsp_ready;

  // -------------------------------------------------------------------------------------------
  // Process 1: state register (all flops, synchronous reset)
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b0;
      v_we_q      <= 1'b0;
      v_addr_q    <= '0;
      v_data_in_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      v_we_q      <= v_we_d;
      v_addr_q    <= v_addr_d;
      v_data_in_q <= v_data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Process 2: next-state logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = cmd_write ? StWrite : StRdWait;
        end
      end
      StWrite: begin
`ifdef BITVAULT_WRITE_VERIFY_EN
        state_d = StVfyWait;
`else
        state_d = StResp;
`endif
      end
      StRdWait: begin
        if (cnt_zero) begin
          state_d = StResp;
        end
      end
`ifdef BITVAULT_WRITE_VERIFY_EN
      StVfyWait: begin
        if (cnt_zero) begin
          state_d = StResp;
        end
      end
`endif
      StResp: begin
        if (rsp_hs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // Process 3: output / datapath next values
  // Control outputs are registered copies of a decode of state_d, so each one is valid in the
  // same cycle the FSM enters the state it belongs to.
  // -------------------------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    v_addr_d    = v_addr_q;
    v_data_in_d = v_data_in_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    cmd_ready_d = (state_d == StIdle);
    v_we_d      = (state_d == StWrite);
    rsp_valid_d = (state_d == StResp);

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          v_addr_d = cmd_addr;
          wdata_d  = cmd_wdata;
          cnt_d    = LatInit;
          if (cmd_write) begin
            v_data_in_d = cmd_wdata;
          end
        end
      end
      StWrite: begin
        // Reload for the read-back; harmless when verify is not built.
        cnt_d = LatInit;
`ifndef BITVAULT_WRITE_VERIFY_EN
        rsp_rdata_d = wdata_q;
        rsp_err_d   = 1'b0;
`endif
      end
      StRdWait: begin
        if (cnt_zero) begin
          rsp_rdata_d = v_data_out;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`ifdef BITVAULT_WRITE_VERIFY_EN
      StVfyWait: begin
        if (cnt_zero) begin
          rsp_rdata_d = v_data_out;
          rsp_err_d   = (v_data_out != wdata_q);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`endif
      default: begin
        // StResp: response registers hold until the handshake.
      end
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  assign cmd_ready = cmd_ready_q;
  assign v_we      = v_we_q;
  assign v_addr    = v_addr_q;
  assign v_data_in = v_data_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);

  // -------------------------------------------------------------------------------------------
  // Protocol invariants
  // -------------------------------------------------------------------------------------------
`ifndef SYNTHESIS
  // A response the host has not taken must not change underneath it.
  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_err)));

  // The vault is only ever written from the WRITE state.
  a_we_in_write: assert property (@(posedge clk) disable iff (rst)
    v_we |-> (state_q == StWrite));

  // Commands are only offered while idle.
  a_ready_idle: assert property (@(posedge clk) disable iff (rst)
    cmd_ready |-> (state_q == StIdle));
`endif

endmodule

// File: tb/tb_bitvault_initiator.sv
module tb_bitvault_initiator;

`ifdef BITVAULT_WRITE_VERIFY_EN
  localparam bit Vfy = 1'b1;
`else
  localparam bit Vfy = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Host side (shared, cmd_valid steered by sel)
  logic [1:0] sel;
  logic       cmd_valid;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_ready;
  logic       force_b0;

  logic       cmd_ready_a   [3];
  logic       rsp_valid_a   [3];
  logic [7:0] rsp_rdata_a   [3];
  logic       rsp_err_a     [3];
  logic       v_we_a        [3];
  logic [1:0] v_addr_a      [3];
  logic [7:0] v_data_in_a   [3];
  logic [7:0] v_data_out_a  [3];
  logic       busy_a        [3];

  // Instances 0/1/2 use RD_LAT 0/1/3, each with its own vault model.
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned Lat = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [7:0] mem [4];
    logic [7:0] rd0, p1, p2, p3;

    bitvault_initiator #(
      .ADDR_W(2),
      .DATA_W(8),
      .RD_LAT(Lat)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid && (sel == 2'(g))),
      .cmd_ready (cmd_ready_a[g]),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid_a[g]),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata_a[g]),
      .rsp_err   (rsp_err_a[g]),
      .v_we      (v_we_a[g]),
      .v_addr    (v_addr_a[g]),
      .v_data_in (v_data_in_a[g]),
      .v_data_out(v_data_out_a[g]),
      .busy      (busy_a[g])
    );

    always_comb rd0 = mem[v_addr_a[g]] & (force_b0 ? 8'hFE : 8'hFF);
    always_ff @(posedge clk) begin
      if (v_we_a[g]) mem[v_addr_a[g]] <= v_data_in_a[g];
      p1 <= rd0;
      p2 <= p1;
      p3 <= p2;
    end
    assign v_data_out_a[g] = (Lat == 0) ? rd0 : (Lat == 1) ? p1 : (Lat == 2) ? p2 : p3;
  end

  logic       cmd_ready_m, rsp_valid_m, rsp_err_m, v_we_m, busy_m;
  logic [7:0] rsp_rdata_m, v_data_in_m;
  logic [1:0] v_addr_m;
  always_comb begin
    cmd_ready_m = cmd_ready_a[sel];
    rsp_valid_m = rsp_valid_a[sel];
    rsp_rdata_m = rsp_rdata_a[sel];
    rsp_err_m   = rsp_err_a[sel];
    v_we_m      = v_we_a[sel];
    v_addr_m    = v_addr_a[sel];
    v_data_in_m = v_data_in_a[sel];
    busy_m      = busy_a[sel];
  end

  // Vault write monitor (observation only)
  int         we_cnt = 0;
  int         we_cyc = -1;
  logic [1:0] we_addr;
  logic [7:0] we_data;
  always @(negedge clk) begin
    if (v_we_m) begin
      we_cnt  = we_cnt + 1;
      we_cyc  = cyc;
      we_addr = v_addr_m;
      we_data = v_data_in_m;
    end
  end

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         exp_cyc;
  } exp_t;

  typedef struct {
    int         acc;
    int         cyc;
    logic [7:0] rdata;
    logic       err;
    logic       after_v;
    bit         ok;
  } obs_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int lat_of(input logic [1:0] s);
    return (s == 2'd0) ? 0 : ((s == 2'd1) ? 1 : 3);
  endfunction

  // Accept-to-rsp_valid distance for the currently selected instance.
  function automatic int exp_lat(input logic w);
    if (w) return Vfy ? (3 + lat_of(sel)) : 2;
    return 2 + lat_of(sel);
  endfunction

  task automatic send_cmd(input logic w, input logic [1:0] a, input logic [7:0] d,
                          output int acc, output bit ok);
    ok  = 1'b0;
    acc = -1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 64; i++) begin
      if (cmd_ready_m) begin
        acc = cyc;
        ok  = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int rc, output logic [7:0] rd, output logic er,
                          output logic after_v, output bit ok);
    ok      = 1'b0;
    rc      = -1;
    rd      = 8'h00;
    er      = 1'b0;
    after_v = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rsp_valid_m) begin
        rc = cyc;
        rd = rsp_rdata_m;
        er = rsp_err_m;
        ok = 1'b1;
        break;
      end
    end
    if (ok && rsp_ready) begin
      @(negedge clk);
      after_v = rsp_valid_m;
    end
  endtask

  task automatic run_txn(input logic w, input logic [1:0] a, input logic [7:0] d,
                         input logic [7:0] rd_exp, input logic err_exp,
                         output exp_t e, output obs_t o);
    int         acc, rc;
    bit         sent, got;
    logic [7:0] rd;
    logic       er, av;
    sb.delete();
    send_cmd(w, a, d, acc, sent);
    if (sent) sb.push_back('{rdata: rd_exp, err: err_exp, exp_cyc: acc + exp_lat(w)});
    wait_rsp(rc, rd, er, av, got);
    e = '{rdata: 8'h00, err: 1'b0, exp_cyc: -2};
    if (got && sb.size() != 0) e = sb.pop_front();
    o = '{acc: acc, cyc: rc, rdata: rd, err: er, after_v: av, ok: got};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_tests++;
      if (cmd_ready_a[s] !== 1'b0 || v_we_a[s] !== 1'b0 || v_addr_a[s] !== 2'd0 ||
          v_data_in_a[s] !== 8'h00 || rsp_valid_a[s] !== 1'b0 || rsp_rdata_a[s] !== 8'h00 ||
          rsp_err_a[s] !== 1'b0 || busy_a[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_values[%0d]: rdy=%b we=%b addr=%h din=%h rv=%b rd=%h err=%b busy=%b, want all 0",
                 s, cmd_ready_a[s], v_we_a[s], v_addr_a[s], v_data_in_a[s], rsp_valid_a[s],
                 rsp_rdata_a[s], rsp_err_a[s], busy_a[s]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmd_ready_a[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_low: cmd_ready=%b in cycle rst falls, want 0", cmd_ready_a[1]);
    end
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_tests++;
      if (cmd_ready_a[s] !== 1'b1 || busy_a[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: cmd_ready=%b busy=%b, want 1 0", s, cmd_ready_a[s],
                 busy_a[s]);
      end
    end
  endtask

  task automatic test_write;
    logic [1:0] addrs [2];
    logic [7:0] datas [2];
    exp_t       e;
    obs_t       o;
    int         we0;
    addrs = '{2'd0, 2'd2};
    datas = '{8'hAA, 8'h55};
    sel = 2'd1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      we0 = we_cnt;
      run_txn(1'b1, addrs[i], datas[i], datas[i], 1'b0, e, o);
      n_tests++;
      if (o.cyc !== e.exp_cyc) begin
        n_fail++;
        $display("FAIL write%0d_latency: rsp_valid cycle %0d, want %0d", i, o.cyc, e.exp_cyc);
      end
      n_tests++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        n_fail++;
        $display("FAIL write%0d_rsp: rdata=%h err=%b, want %h %b", i, o.rdata, o.err,
                 e.rdata, e.err);
      end
      n_tests++;
      if (o.after_v !== 1'b0) begin
        n_fail++;
        $display("FAIL write%0d_resp_one_cycle: rsp_valid=%b after handshake, want 0", i,
                 o.after_v);
      end
      n_tests++;
      if (we_cnt - we0 !== 1 || we_addr !== addrs[i] || we_data !== datas[i] ||
          we_cyc !== o.acc + 1) begin
        n_fail++;
        $display("FAIL write%0d_we_pulse: pulses=%0d addr=%h data=%h cycle=%0d, want 1 %h %h %0d",
                 i, we_cnt - we0, we_addr, we_data, we_cyc, addrs[i], datas[i], o.acc + 1);
      end
    end
  endtask

  task automatic test_read;
    logic [1:0] addrs [2];
    logic [7:0] datas [2];
    exp_t       e;
    obs_t       o;
    addrs = '{2'd0, 2'd2};
    datas = '{8'hAA, 8'h55};
    sel = 2'd1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_txn(1'b0, addrs[i], 8'h00, datas[i], 1'b0, e, o);
      n_tests++;
      if (o.cyc !== e.exp_cyc || o.cyc - o.acc !== 3) begin
        n_fail++;
        $display("FAIL read%0d_latency: rsp_valid cycle %0d, want %0d (accept+3)", i, o.cyc,
                 e.exp_cyc);
      end
      n_tests++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        n_fail++;
        $display("FAIL read%0d_rsp: rdata=%h err=%b, want %h %b", i, o.rdata, o.err,
                 e.rdata, e.err);
      end
    end
  endtask

  task automatic test_back_to_back_hold;
    int         acc, acc2, hs, rc, we0;
    bit         ok;
    logic [7:0] rd;
    logic       er, av;
    exp_t       e;
    exp_t       e2;
    obs_t       o;
    sel = 2'd1;
    rsp_ready = 1'b0;
    sb.delete();
    send_cmd(1'b0, 2'd2, 8'h00, acc, ok);
    if (ok) sb.push_back('{rdata: 8'h55, err: 1'b0, exp_cyc: acc + exp_lat(1'b0)});
    rc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rsp_valid_m) begin
        rc = cyc;
        break;
      end
    end
    e = '{rdata: 8'h00, err: 1'b0, exp_cyc: -2};
    if (sb.size() != 0) e = sb.pop_front();
    n_tests++;
    if (rc !== e.exp_cyc) begin
      n_fail++;
      $display("FAIL hold_read_latency: rsp_valid cycle %0d, want %0d", rc, e.exp_cyc);
    end
    // Offer a write while the response is pending.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 2'd2;
    cmd_wdata = 8'hFF;
    we0 = we_cnt;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if (rsp_valid_m !== 1'b1 || rsp_rdata_m !== e.rdata || rsp_err_m !== 1'b0 ||
          cmd_ready_m !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: rsp_valid=%b rdata=%h err=%b cmd_ready=%b, want 1 %h 0 0",
                 i, rsp_valid_m, rsp_rdata_m, rsp_err_m, cmd_ready_m, e.rdata);
      end
    end
    rsp_ready = 1'b1;
    hs = cyc;
    acc2 = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cmd_ready_m) begin
        acc2 = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n_tests++;
    if (acc2 !== hs + 1 || we_cnt !== we0) begin
      n_fail++;
      $display("FAIL hold_next_accept: accept cycle %0d writes %0d, want %0d 0", acc2,
               we_cnt - we0, hs + 1);
    end
    if (acc2 >= 0) sb.push_back('{rdata: 8'hFF, err: 1'b0, exp_cyc: acc2 + exp_lat(1'b1)});
    wait_rsp(rc, rd, er, av, ok);
    e2 = '{rdata: 8'h00, err: 1'b0, exp_cyc: -2};
    if (ok && sb.size() != 0) e2 = sb.pop_front();
    n_tests++;
    if (rc !== e2.exp_cyc || rd !== e2.rdata || er !== e2.err) begin
      n_fail++;
      $display("FAIL hold_write_rsp: cycle %0d rdata=%h err=%b, want %0d %h %b", rc, rd, er,
               e2.exp_cyc, e2.rdata, e2.err);
    end
    run_txn(1'b0, 2'd2, 8'h00, 8'hFF, 1'b0, e, o);
    n_tests++;
    if (o.rdata !== e.rdata || o.cyc !== e.exp_cyc) begin
      n_fail++;
      $display("FAIL hold_readback: rdata=%h cycle %0d, want %h %0d", o.rdata, o.cyc, e.rdata,
               e.exp_cyc);
    end
  endtask

  task automatic test_reset_mid;
    int   acc, seen;
    bit   ok;
    exp_t e;
    obs_t o;
    sel = 2'd1;
    rsp_ready = 1'b1;
    send_cmd(1'b1, 2'd1, 8'h33, acc, ok);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (v_we_m !== 1'b1 || v_data_in_m !== 8'h33 || v_addr_m !== 2'd1) begin
      n_fail++;
      $display("FAIL midrst_we_cycle1: we=%b addr=%h din=%h, want 1 1 33", v_we_m, v_addr_m,
               v_data_in_m);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (v_we_m !== 1'b0 || v_addr_m !== 2'd0 || v_data_in_m !== 8'h00 ||
        rsp_valid_m !== 1'b0 || rsp_rdata_m !== 8'h00 || rsp_err_m !== 1'b0 ||
        busy_m !== 1'b0 || cmd_ready_m !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: we=%b addr=%h din=%h rv=%b rd=%h err=%b busy=%b rdy=%b, want all 0",
               v_we_m, v_addr_m, v_data_in_m, rsp_valid_m, rsp_rdata_m, rsp_err_m, busy_m,
               cmd_ready_m);
    end
    seen = 0;
    @(negedge clk);
    n_tests++;
    if (cmd_ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: cmd_ready=%b cycle after rst falls, want 1", cmd_ready_m);
    end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid_m) seen++;
      @(negedge clk);
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midrst_no_rsp: %0d response cycles, want 0", seen);
    end
    // The write was already on the vault pins when reset hit, so it landed.
    run_txn(1'b0, 2'd1, 8'h00, 8'h33, 1'b0, e, o);
    n_tests++;
    if (o.rdata !== e.rdata || o.cyc !== e.exp_cyc) begin
      n_fail++;
      $display("FAIL midrst_readback: rdata=%h cycle %0d, want %h %0d", o.rdata, o.cyc,
               e.rdata, e.exp_cyc);
    end
  endtask

  task automatic test_verify;
    exp_t e;
    obs_t o;
    sel = 2'd1;
    rsp_ready = 1'b1;
    force_b0 = 1'b1;
    run_txn(1'b1, 2'd3, 8'h01, Vfy ? 8'h00 : 8'h01, Vfy, e, o);
    force_b0 = 1'b0;
    n_tests++;
    if (o.rdata !== e.rdata || o.err !== e.err) begin
      n_fail++;
      $display("FAIL verify_rsp: rdata=%h err=%b, want %h %b", o.rdata, o.err, e.rdata, e.err);
    end
    n_tests++;
    if (o.cyc !== e.exp_cyc) begin
      n_fail++;
      $display("FAIL verify_latency: rsp_valid cycle %0d, want %0d", o.cyc, e.exp_cyc);
    end
  endtask

  task automatic test_rd_lat;
    logic [1:0] sels [2];
    int         want [2];
    exp_t       e;
    obs_t       o;
    sels = '{2'd0, 2'd2};
    want = '{2, 5};
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sel = sels[i];
      run_txn(1'b1, 2'd0, 8'hAA, 8'hAA, 1'b0, e, o);
      n_tests++;
      if (o.cyc !== e.exp_cyc || o.rdata !== e.rdata || o.err !== e.err) begin
        n_fail++;
        $display("FAIL rdlat%0d_write: cycle %0d rdata=%h err=%b, want %0d %h %b",
                 lat_of(sels[i]), o.cyc, o.rdata, o.err, e.exp_cyc, e.rdata, e.err);
      end
      run_txn(1'b0, 2'd0, 8'h00, 8'hAA, 1'b0, e, o);
      n_tests++;
      if (o.cyc !== e.exp_cyc || o.cyc - o.acc !== want[i] || o.rdata !== e.rdata) begin
        n_fail++;
        $display("FAIL rdlat%0d_read: latency %0d rdata=%h, want %0d %h", lat_of(sels[i]),
                 o.cyc - o.acc, o.rdata, want[i], e.rdata);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    sel       = 2'd1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 2'd0;
    cmd_wdata = 8'h00;
    rsp_ready = 1'b1;
    force_b0  = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back_hold();
    test_reset_mid();
    test_verify();
    test_rd_lat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
